// File: rtl/mat_addr_seq.sv
// Address sequencer for the matrix-multiply datapath: walks i, j, k (k fastest)
// and emits A/B read addresses and the C address using adders only.
module mat_addr_seq #(
  parameter int ADDR_BITS = 7,
  parameter int M         = 8,
  parameter int K         = 8,
  parameter int N         = 8,
  parameter int A_BASE    = 0,
  parameter int B_BASE    = 0,
  parameter int C_BASE    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 b_colmajor,
  input  logic                 addr_ready,
  output logic                 addr_valid,
  output logic [ADDR_BITS-1:0] Dir_A,
  output logic [ADDR_BITS-1:0] Dir_B,
  output logic [ADDR_BITS-1:0] Dir_C,
  output logic                 acc_clr,
  output logic                 acc_last,
  output logic                 busy,
  output logic                 done
);

  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam int JW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;

  localparam logic [ADDR_BITS-1:0] A0    = ADDR_BITS'(A_BASE);
  localparam logic [ADDR_BITS-1:0] B0    = ADDR_BITS'(B_BASE);
  localparam logic [ADDR_BITS-1:0] C0    = ADDR_BITS'(C_BASE);
  localparam logic [ADDR_BITS-1:0] KSTEP = ADDR_BITS'(K);
  localparam logic [ADDR_BITS-1:0] NSTEP = ADDR_BITS'(N);
  localparam logic [ADDR_BITS-1:0] ONE   = ADDR_BITS'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nx;

  logic [IW-1:0]        i;
  logic [JW-1:0]        j;
  logic [KW-1:0]        k;
  logic                 bcol;
  logic [ADDR_BITS-1:0] a_row;    // A_BASE + i*K
  logic [ADDR_BITS-1:0] b_col0;   // address of B(k=0, j) in the latched layout
  logic [ADDR_BITS-1:0] a_row_nx;
  logic [ADDR_BITS-1:0] b_col0_nx;
  logic [ADDR_BITS-1:0] b_kstep;
  logic                 clr_q;
  logic                 last_q;
  logic                 xfer;
  logic                 k_end;
  logic                 j_end;
  logic                 i_end;

  assign xfer      = (state == RUN) && addr_ready;
  assign k_end     = (int'(k) == K - 1);
  assign j_end     = (int'(j) == N - 1);
  assign i_end     = (int'(i) == M - 1);
  assign a_row_nx  = a_row + KSTEP;
  assign b_col0_nx = b_col0 + (bcol ? KSTEP : ONE);
  assign b_kstep   = bcol ? ONE : NSTEP;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    addr_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        addr_valid = 1'b1;
        busy       = 1'b1;
        if (xfer && k_end && j_end && i_end) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    acc_clr  = clr_q & addr_valid;
    acc_last = last_q & addr_valid;
  end

  // Final transfer leaves every address untouched so the last beat stays visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i      <= '0;
      j      <= '0;
      k      <= '0;
      bcol   <= 1'b0;
      a_row  <= '0;
      b_col0 <= '0;
      Dir_A  <= '0;
      Dir_B  <= '0;
      Dir_C  <= '0;
      clr_q  <= 1'b0;
      last_q <= 1'b0;
    end else if (state == IDLE && start) begin
      i      <= '0;
      j      <= '0;
      k      <= '0;
      bcol   <= b_colmajor;
      a_row  <= A0;
      b_col0 <= B0;
      Dir_A  <= A0;
      Dir_B  <= B0;
      Dir_C  <= C0;
      clr_q  <= 1'b1;
      last_q <= (K == 1);
    end else if (xfer && !(k_end && j_end && i_end)) begin
      if (!k_end) begin
        k      <= k + KW'(1);
        Dir_A  <= Dir_A + ONE;
        Dir_B  <= Dir_B + b_kstep;
        clr_q  <= 1'b0;
        last_q <= (int'(k) == K - 2);
      end else begin
        k      <= '0;
        clr_q  <= 1'b1;
        last_q <= (K == 1);
        Dir_C  <= Dir_C + ONE;
        if (!j_end) begin
          j      <= j + JW'(1);
          Dir_A  <= a_row;
          b_col0 <= b_col0_nx;
          Dir_B  <= b_col0_nx;
        end else begin
          j      <= '0;
          i      <= i + IW'(1);
          a_row  <= a_row_nx;
          Dir_A  <= a_row_nx;
          b_col0 <= B0;
          Dir_B  <= B0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mat_addr_seq.sv
// Scoreboard bench for mat_addr_seq: four parameter sets, expected beats from
// plain i/j/k arithmetic, checked by a monitor independent of the stimulus.
module tb_mat_addr_seq;

  localparam int NU = 4;
  localparam int PM [NU] = '{8, 2, 2, 3};
  localparam int PK [NU] = '{8, 3, 1, 5};
  localparam int PN [NU] = '{8, 4, 2, 7};
  localparam int PA [NU] = '{0, 16, 0, 120};
  localparam int PB [NU] = '{0, 32, 0, 100};
  localparam int PC [NU] = '{0, 64, 0, 127};

  typedef struct {
    int          u;
    logic [22:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic b_colmajor = 1'b0;
  logic [NU-1:0] start_v = '0;
  logic [NU-1:0] ready_v = '1;
  logic [NU-1:0] valid_v, busy_v, done_v, clr_v, last_v;
  logic [NU-1:0][6:0] dira, dirb, dirc;

  exp_t sbq [$];
  int   runq [$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mat_addr_seq #(.ADDR_BITS(7), .M(PM[0]), .K(PK[0]), .N(PN[0]),
                 .A_BASE(PA[0]), .B_BASE(PB[0]), .C_BASE(PC[0])) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .b_colmajor(b_colmajor),
    .addr_ready(ready_v[0]), .addr_valid(valid_v[0]), .Dir_A(dira[0]),
    .Dir_B(dirb[0]), .Dir_C(dirc[0]), .acc_clr(clr_v[0]), .acc_last(last_v[0]),
    .busy(busy_v[0]), .done(done_v[0]));

  mat_addr_seq #(.ADDR_BITS(7), .M(PM[1]), .K(PK[1]), .N(PN[1]),
                 .A_BASE(PA[1]), .B_BASE(PB[1]), .C_BASE(PC[1])) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .b_colmajor(b_colmajor),
    .addr_ready(ready_v[1]), .addr_valid(valid_v[1]), .Dir_A(dira[1]),
    .Dir_B(dirb[1]), .Dir_C(dirc[1]), .acc_clr(clr_v[1]), .acc_last(last_v[1]),
    .busy(busy_v[1]), .done(done_v[1]));

  mat_addr_seq #(.ADDR_BITS(7), .M(PM[2]), .K(PK[2]), .N(PN[2]),
                 .A_BASE(PA[2]), .B_BASE(PB[2]), .C_BASE(PC[2])) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .b_colmajor(b_colmajor),
    .addr_ready(ready_v[2]), .addr_valid(valid_v[2]), .Dir_A(dira[2]),
    .Dir_B(dirb[2]), .Dir_C(dirc[2]), .acc_clr(clr_v[2]), .acc_last(last_v[2]),
    .busy(busy_v[2]), .done(done_v[2]));

  mat_addr_seq #(.ADDR_BITS(7), .M(PM[3]), .K(PK[3]), .N(PN[3]),
                 .A_BASE(PA[3]), .B_BASE(PB[3]), .C_BASE(PC[3])) u3 (
    .clk(clk), .rst(rst), .start(start_v[3]), .b_colmajor(b_colmajor),
    .addr_ready(ready_v[3]), .addr_valid(valid_v[3]), .Dir_A(dira[3]),
    .Dir_B(dirb[3]), .Dir_C(dirc[3]), .acc_clr(clr_v[3]), .acc_last(last_v[3]),
    .busy(busy_v[3]), .done(done_v[3]));

  task automatic chk(input string nm, input int u, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s unit%0d t=%0t got=%0h expected=%0h", nm, u, $time, got, exp);
    end
  endtask

  // Reference: every beat of the sweep from the index formulas, modulo 128.
  function automatic void push_run(input int u, input bit bc);
    exp_t e;
    int a, b, c;
    for (int i = 0; i < PM[u]; i++)
      for (int j = 0; j < PN[u]; j++)
        for (int k = 0; k < PK[u]; k++) begin
          a = PA[u] + i * PK[u] + k;
          b = bc ? PB[u] + j * PK[u] + k : PB[u] + k * PN[u] + j;
          c = PC[u] + i * PN[u] + j;
          e.u = u;
          e.v = {7'(a), 7'(b), 7'(c), (k == 0), (k == PK[u] - 1)};
          sbq.push_back(e);
        end
    runq.push_back(PM[u] * PN[u] * PK[u]);
  endfunction

  function automatic logic [22:0] cur(input int u);
    return {dira[u], dirb[u], dirc[u], clr_v[u], last_v[u]};
  endfunction

  // Monitor
  logic [NU-1:0] go_pend = '0;
  logic [NU-1:0] idle_pend = '0;
  bit          hold_v = 0;
  int          hold_u = 0;
  logic [22:0] hold_b = '0;
  bit          in_run = 0;
  int          cur_u = 0;
  int          cur_beats = 0;
  int          busy_cnt = 0;
  int          stall_cnt = 0;
  int          age = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int u = 0; u < NU; u++)
        chk("reset_outputs", u, {6'd0, valid_v[u], busy_v[u], done_v[u], clr_v[u],
                                 last_v[u], dira[u], dirb[u], dirc[u]}, 32'd0);
      sbq.delete();
      runq.delete();
      go_pend = '0;
      idle_pend = '0;
      hold_v = 0;
      in_run = 0;
      age = 0;
    end else begin
      for (int u = 0; u < NU; u++) begin
        if (idle_pend[u]) begin
          chk("busy_after_done", u, {31'd0, busy_v[u]}, 32'd0);
          idle_pend[u] = 1'b0;
        end
        if (go_pend[u]) begin
          chk("start_latency", u, {30'd0, valid_v[u], busy_v[u]}, 32'd3);
          go_pend[u] = 1'b0;
          in_run = 1;
          cur_u = u;
          cur_beats = (runq.size() != 0) ? runq.pop_front() : -1;
          busy_cnt = 0;
          stall_cnt = 0;
        end
        if (start_v[u] && !busy_v[u]) go_pend[u] = 1'b1;
        if (hold_v && hold_u == u) begin
          if (valid_v[u]) chk("stall_hold", u, {9'd0, cur(u)}, {9'd0, hold_b});
          hold_v = 0;
        end
        if (valid_v[u]) begin
          if (ready_v[u]) begin
            if (sbq.size() == 0) begin
              errors++;
              checks++;
              $display("FAIL extra_beat unit%0d t=%0t got=%0h expected=none", u, $time, cur(u));
            end else begin
              e = sbq.pop_front();
              chk("beat_unit", u, u, e.u);
              chk("beat", u, {9'd0, cur(u)}, {9'd0, e.v});
              age = 0;
            end
          end else begin
            hold_v = 1;
            hold_u = u;
            hold_b = cur(u);
            if (in_run && cur_u == u) stall_cnt++;
          end
        end
        if (busy_v[u] && in_run && cur_u == u) busy_cnt++;
        if (done_v[u]) begin
          if (in_run && cur_u == u) begin
            chk("done_cycle", u, busy_cnt, cur_beats + 1 + stall_cnt);
            chk("done_leftover", u, sbq.size(), 0);
            chk("done_valid", u, {31'd0, valid_v[u]}, 32'd0);
            in_run = 0;
            idle_pend[u] = 1'b1;
          end else begin
            errors++;
            checks++;
            $display("FAIL spurious_done unit%0d t=%0t got=1 expected=0", u, $time);
          end
        end
      end
      if (sbq.size() != 0) age++;
      if (age > 300) begin
        errors++;
        checks++;
        $display("FAIL watchdog t=%0t got=%0d pending expected=0", $time, sbq.size());
        sbq.delete();
        runq.delete();
        in_run = 0;
        age = 0;
      end
    end
  end

  // mode: 0 ready high, 1 random ready, 2 stall on beat 10,
  //       3 extra start at beat 100, 4 reset at beat 200
  task automatic do_run(input int u, input bit bc, input int mode);
    int cnt;
    push_run(u, bc);
    b_colmajor = bc;
    start_v[u] = 1'b1;
    @(posedge clk);
    #1;
    start_v[u] = 1'b0;
    cnt = 0;
    while (!done_v[u] && cnt < 4000) begin
      case (mode)
        1:       ready_v[u] = ($urandom_range(0, 3) != 0);
        2:       ready_v[u] = !(cnt >= 10 && cnt < 13);
        default: ready_v[u] = 1'b1;
      endcase
      start_v[u] = (mode == 3 && cnt == 100);
      if (mode == 4 && cnt == 200) begin
        #2 rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      cnt++;
    end
    start_v[u] = 1'b0;
    ready_v[u] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    do_run(0, 1'b0, 0);
    do_run(0, 1'b0, 2);
    do_run(0, 1'b0, 3);
    do_run(0, 1'($urandom_range(0, 1)), 1);
    do_run(0, 1'b0, 4);
    repeat (3) @(posedge clk);
    #1;
    do_run(0, 1'b1, 1);
    do_run(1, 1'b1, 0);
    for (int r = 0; r < 4; r++) do_run(1, 1'($urandom_range(0, 1)), 1);
    do_run(2, 1'b0, 0);
    do_run(2, 1'b1, 1);
    for (int r = 0; r < 3; r++) do_run(3, 1'($urandom_range(0, 1)), 1);
    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mat_addr_seq.md
# mat_addr_seq

Parametrised address sequencer for the matrix-multiply datapath. It generates read addresses for operand memories A (M×K) and B (K×N) and the write address for result memory C (M×N). Loop order is i (row of A), then j (column of B), then k (inner index, fastest). It supports arbitrary M/K/N, configurable base addresses, row- or column-major B layout, a start/done handshake and downstream back-pressure. It sits between the control FSM and the operand RAMs / MAC accumulator.

## Interface
Parameters:
- ADDR_BITS, 7: width of all address outputs
- M, 8: rows of A and C (≥1)
- K, 8: inner dimension (≥1)
- N, 8: columns of B and C (≥1)
- A_BASE, 0: base address of A
- B_BASE, 0: base address of B
- C_BASE, 0: base address of C

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a full M×N×K sweep; sampled only in IDLE
- b_colmajor  in  1  B layout, latched on accepted start: 0 row-major, 1 column-major
- addr_ready  in  1  downstream accepts the current beat
- addr_valid  out  1  current beat on Dir_A/Dir_B/Dir_C/flags is valid
- Dir_A  out  ADDR_BITS  A read address
- Dir_B  out  ADDR_BITS  B read address
- Dir_C  out  ADDR_BITS  C address for the current (i,j)
- acc_clr  out  1  first beat of a dot product (k==0)
- acc_last  out  1  last beat of a dot product (k==K-1); the C write is due on this beat
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse after the final beat transfers

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - On start: latch b_colmajor, zero i/j/k, load the beat-0 addresses, go to RUN.
  - Otherwise hold.
- RUN:
  - addr_valid=1.
  - A beat transfers when addr_valid && addr_ready.
  - While addr_ready=0, all outputs hold.
  - On transfer, advance k; on k wrap advance j; on j wrap advance i.
  - On the transfer of beat (M-1, N-1, K-1), go to DONE.
- DONE: done=1, addr_valid=0 for one cycle, then go to IDLE.
- start outside IDLE is ignored. It does not queue and does not restart.
- Address arithmetic (computed incrementally with adders only, no multipliers):
  - Dir_A = A_BASE + i·K + k
  - Dir_B = B_BASE + k·N + j (row-major) or B_BASE + j·K + k (column-major)
  - Dir_C = C_BASE + i·N + j
- All sums wrap modulo 2^ADDR_BITS. No overflow flag.
- acc_clr = (k==0), acc_last = (k==K-1). Both are registered, aligned with the addresses, and qualified by addr_valid.
- K=1: acc_clr and acc_last are both 1 on every beat.
- M=N=K=1: a single beat, then DONE.

## Timing
- Reset (async, any state): state=IDLE. Every output is 0: addr_valid, Dir_A, Dir_B, Dir_C, acc_clr, acc_last, busy, done. The latched b_colmajor is also 0.
- Reset mid-RUN aborts the sweep immediately. No done pulse is produced.
- Addresses hold their last value in IDLE/DONE and are meaningful only with addr_valid.
- start sampled at edge t → at t+1: addr_valid=1, busy=1, beat-0 addresses present.
- With addr_ready held high, one beat per cycle; the final beat is present at t+M·N·K.
- done=1 during cycle t+M·N·K+1; busy drops and IDLE is reached at the next edge.
- Each cycle of addr_ready=0 in RUN delays done by exactly one cycle.
- addr_ready has no effect outside RUN.
- The earliest accepted next start is the cycle after the done pulse.

## Test plan
- Defaults (8×8×8, row-major), start at t, addr_ready=1 → 512 beats. Beat 9 is (i=0, j=1, k=1): Dir_A=1, Dir_B=9, Dir_C=1, acc_clr=0, acc_last=0. Final beat: Dir_A=63, Dir_B=63, Dir_C=63, acc_last=1. done pulses at t+513.
- M=2, K=3, N=4, A_BASE=16, B_BASE=32, C_BASE=64, b_colmajor=1 → 24 beats. Beat 5 is (i=0, j=1, k=2): Dir_A=18, Dir_B=37, Dir_C=65, acc_last=1. Beat 23: Dir_A=21, Dir_B=43, Dir_C=71.
- Defaults, addr_ready forced 0 for 3 cycles while beat 10 is presented → outputs are stable across all 3 cycles, beat 11 follows the transfer, done is delayed to t+516.
- start pulsed again at beat 100 of a run → ignored; the sweep completes normally with a single done. A start right after done restarts from beat 0.
- K=1, M=N=2 → 4 beats, acc_clr=acc_last=1 on each. Dir_C sequence is 0,1,2,3.
- rst driven low at beat 200 → all outputs are 0 asynchronously, no done pulse. After release, a new start begins at beat 0.
